// File: rtl/uart_pixel_rx.sv
// 8N1 receiver that pairs bytes into 12-bit pixels, locks on a start marker and tags each pixel with its frame address.
// Latency: pixel_valid/rx_error are registered 1 cycle after the stop-bit sample (plus 2-cycle input synchroniser).
// No backpressure: the serial line cannot be stalled, so every output is a fire-and-forget strobe.
module uart_pixel_rx #(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int          BAUD_RATE    = 115200,
  parameter int          NUM_PIXELS   = 76800,
  parameter logic [11:0] START_PIXEL  = 12'h00A,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_in,
  output logic [11:0] pixel_out,
  output logic [16:0] pixel_addr,
  output logic        pixel_valid,
  output logic        frame_active,
  output logic        frame_done,
  output logic        rx_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
  typedef enum logic {EXP_HI, EXP_LO} pair_state_t;
  typedef enum logic {SEARCH, RECV} frame_state_t;

  logic          rx_meta, rx_sync, rx_prev;
  bit_state_t    bit_state, bit_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_dat;
  pair_state_t   pair_state, pair_next;
  logic [3:0]    hi_nib;
  logic [TW-1:0] to_cnt;
  frame_state_t  frame_state, frame_next;
  logic [16:0]   addr_cnt;

  logic          fall, bit_tick, stop_sample, byte_vld, frame_err;
  logic          pix_vld, err_vld, timeout, emit_vld, emit_done;
  logic [11:0]   pix_dat;

  assign fall      = rx_prev & ~rx_sync;
  assign byte_vld  = stop_sample & rx_sync;
  assign frame_err = stop_sample & ~rx_sync;
  assign timeout   = (to_cnt == TW'(TIMEOUT_CLKS - 1));

  always_comb begin
    bit_next    = bit_state;
    bit_tick    = 1'b0;
    stop_sample = 1'b0;
    case (bit_state)
      IDLE:  if (fall) bit_next = START;
      START: if (clk_cnt == CW'(HALF_BIT - 1)) bit_next = rx_sync ? IDLE : DATA;
      DATA: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          bit_tick = 1'b1;
          if (bit_cnt == 3'd7) bit_next = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          stop_sample = 1'b1;
          bit_next    = IDLE;
        end
      end
      default: bit_next = IDLE;
    endcase
  end

  always_comb begin
    pair_next = pair_state;
    pix_vld   = 1'b0;
    pix_dat   = {hi_nib, shift_dat};
    err_vld   = frame_err;
    case (pair_state)
      EXP_HI: begin
        if (byte_vld) begin
          // A nonzero upper nibble means we are misaligned; stay put to resync.
          if (shift_dat[7:4] != 4'h0) err_vld = 1'b1;
          else pair_next = EXP_LO;
        end
      end
      EXP_LO: begin
        if (byte_vld) begin
          pix_vld   = 1'b1;
          pair_next = EXP_HI;
        end else if (frame_err) begin
          pair_next = EXP_HI;
        end else if (timeout) begin
          err_vld   = 1'b1;
          pair_next = EXP_HI;
        end
      end
      default: pair_next = EXP_HI;
    endcase
  end

  always_comb begin
    frame_next = frame_state;
    emit_vld   = 1'b0;
    emit_done  = 1'b0;
    case (frame_state)
      SEARCH: if (pix_vld && pix_dat == START_PIXEL) frame_next = RECV;
      RECV: begin
        if (err_vld) begin
          frame_next = SEARCH;
        end else if (pix_vld) begin
          emit_vld = 1'b1;
          if (addr_cnt == 17'(NUM_PIXELS - 1)) begin
            emit_done  = 1'b1;
            frame_next = SEARCH;
          end
        end
      end
      default: frame_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      bit_state    <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift_dat    <= '0;
      pair_state   <= EXP_HI;
      hi_nib       <= '0;
      to_cnt       <= '0;
      frame_state  <= SEARCH;
      addr_cnt     <= '0;
      pixel_out    <= '0;
      pixel_addr   <= '0;
      pixel_valid  <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      rx_meta   <= uart_in;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      bit_state <= bit_next;

      if (bit_state == IDLE || bit_next != bit_state || bit_tick) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;

      if (bit_state == START) bit_cnt <= '0;
      else if (bit_tick) bit_cnt <= bit_cnt + 1'b1;

      if (bit_tick) shift_dat <= {rx_sync, shift_dat[7:1]};

      pair_state <= pair_next;
      if (pair_state == EXP_HI && byte_vld) hi_nib <= shift_dat[3:0];
      // Idle-gap timer only runs while holding a half pixel.
      if (pair_state == EXP_LO && pair_next == EXP_LO) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;

      frame_state <= frame_next;
      if (frame_state == SEARCH) addr_cnt <= '0;
      else if (emit_vld) addr_cnt <= addr_cnt + 1'b1;

      if (emit_vld) begin
        pixel_out  <= pix_dat;
        pixel_addr <= addr_cnt;
      end
      pixel_valid  <= emit_vld;
      frame_done   <= emit_done;
      rx_error     <= err_vld;
      frame_active <= (frame_state == RECV);
    end
  end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Bench for uart_pixel_rx: table-driven frame vectors plus hand sequences for error, timeout, glitch and reset cases.
module tb_uart_pixel_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_in = 1'b1;
  logic [11:0] pixel_out;
  logic [16:0] pixel_addr;
  logic        pixel_valid, frame_active, frame_done, rx_error;

  always #5 clk = ~clk;

  uart_pixel_rx #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .NUM_PIXELS(4),
    .START_PIXEL(12'h00A), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in),
    .pixel_out(pixel_out), .pixel_addr(pixel_addr), .pixel_valid(pixel_valid),
    .frame_active(frame_active), .frame_done(frame_done), .rx_error(rx_error)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] pix;
    logic        done;
  } exp_t;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        exp_vld;
    logic [16:0] exp_addr;
    logic [11:0] exp_pix;
    logic        exp_done;
    logic        exp_active;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0, passed = 0;
  int   err_cnt = 0, done_cnt = 0, valid_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      uart_in = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
  endtask

  // Scoreboard: every pixel_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_error) err_cnt++;
      if (frame_done) done_cnt++;
      if (pixel_valid) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_pixel_valid", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pixel_addr", 32'(pixel_addr), 32'(e.addr));
          check("pixel_out", 32'(pixel_out), 32'(e.pix));
          check("frame_done_with_valid", 32'(frame_done), 32'(e.done));
        end
      end else if (frame_done) begin
        check("frame_done_without_valid", 32'(pixel_valid), 32'd1);
      end
    end
  end

  initial begin
    int   e0, v0, t;
    logic nz;

    vecs[0] = '{8'h00, 8'h0A, 1'b0, 17'd0, 12'h000, 1'b0, 1'b1};
    vecs[1] = '{8'h0F, 8'hF0, 1'b1, 17'd0, 12'hFF0, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 8'h23, 1'b1, 17'd1, 12'h123, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h0A, 1'b1, 17'd2, 12'h00A, 1'b0, 1'b1};
    vecs[4] = '{8'h0A, 8'hBC, 1'b1, 17'd3, 12'hABC, 1'b1, 1'b0};

    // Reset values, then a long idle line
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(1);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_pixel_addr", 32'(pixel_addr), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_rx_error", 32'(rx_error), 32'd0);
    nz = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (pixel_out != 0 || pixel_addr != 0 || pixel_valid || frame_active || frame_done || rx_error)
        nz = 1'b1;
    end
    check("idle_outputs_zero", 32'(nz), 32'd0);

    // Full frame from the vector table
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_vld) sb.push_back('{vecs[i].exp_addr, vecs[i].exp_pix, vecs[i].exp_done});
      send_pixel(vecs[i].hi, vecs[i].lo);
      wait_cycles(4);
      check($sformatf("drain_vec%0d", i), 32'(sb.size()), 32'd0);
      check($sformatf("active_vec%0d", i), 32'(frame_active), 32'(vecs[i].exp_active));
    end
    check("frame_done_count", 32'(done_cnt), 32'd1);
    check("frame_no_errors", 32'(err_cnt - e0), 32'd0);

    // Stop-bit framing error aborts the frame
    send_pixel(8'h00, 8'h0A);
    wait_cycles(4);
    check("abort_locked", 32'(frame_active), 32'd1);
    e0 = err_cnt; v0 = valid_cnt;
    send_byte(8'h00, 1'b0);
    wait_cycles(4);
    check("abort_err_pulse", 32'(err_cnt - e0), 32'd1);
    check("abort_inactive", 32'(frame_active), 32'd0);
    send_pixel(8'h0F, 8'hF0);
    wait_cycles(4);
    check("abort_search_ignores", 32'(valid_cnt - v0), 32'd0);
    check("abort_done_unchanged", 32'(done_cnt), 32'd1);

    // Bad high byte in SEARCH, then lock
    e0 = err_cnt;
    send_byte(8'h50, 1'b1);
    wait_cycles(4);
    check("nibble_err", 32'(err_cnt - e0), 32'd1);
    send_pixel(8'h00, 8'h0A);
    wait_cycles(4);
    check("nibble_then_lock", 32'(frame_active), 32'd1);

    // Half-pixel timeout: error roughly 20 bit periods after the high byte
    e0 = err_cnt; t = -1;
    send_byte(8'h03, 1'b1);
    for (int c = 0; c < 25 * CPB; c++) begin
      @(negedge clk);
      if (rx_error && t < 0) t = c;
    end
    if (t < 305 || t > 320) $display("FAIL timeout_delay: got %0d cycles, expected 305..320", t);
    check("timeout_delay_in_window", 32'(t >= 305 && t <= 320), 32'd1);
    check("timeout_err_count", 32'(err_cnt - e0), 32'd1);
    check("timeout_aborts", 32'(frame_active), 32'd0);
    send_pixel(8'h00, 8'h0A);
    wait_cycles(4);
    check("timeout_relock", 32'(frame_active), 32'd1);

    // Quarter-bit glitch is ignored
    e0 = err_cnt; v0 = valid_cnt;
    @(negedge clk);
    uart_in = 1'b0;
    wait_cycles(CPB / 4);
    uart_in = 1'b1;
    wait_cycles(2 * CPB);
    check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_still_active", 32'(frame_active), 32'd1);

    sb.push_back('{17'd0, 12'h123, 1'b0});
    send_pixel(8'h01, 8'h23);
    wait_cycles(4);
    check("pre_reset_drain", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-byte, mid-frame
    send_byte(8'h04, 1'b1);
    fork
      send_byte(8'h05, 1'b1);
      begin
        wait_cycles(5 * CPB);
        rst_n = 1'b0;
        #1;
        check("arst_pixel_out", 32'(pixel_out), 32'd0);
        check("arst_pixel_addr", 32'(pixel_addr), 32'd0);
        check("arst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("arst_frame_active", 32'(frame_active), 32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        check("arst_rx_error", 32'(rx_error), 32'd0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2 * CPB);
    v0 = valid_cnt;
    send_pixel(8'h05, 8'h67);
    wait_cycles(4);
    check("post_reset_search", 32'(valid_cnt - v0), 32'd0);
    send_pixel(8'h00, 8'h0A);
    sb.push_back('{17'd0, 12'hABC, 1'b0});
    send_pixel(8'h0A, 8'hBC);
    wait_cycles(4);
    check("post_reset_drain", 32'(sb.size()), 32'd0);
    check("post_reset_active", 32'(frame_active), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
